// File: rtl/apb_node_pkg.sv
// Shared types for the APB fan-out node with per-transfer watchdog.
// Holds the FSM encoding, the error-type constants and an index-width helper.
package apb_node_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic ERR_DECODE  = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Range decoder: start <= addr < end per slave.
// When regions overlap, the lowest slave index wins.
module apb_addr_decoder
  import apb_node_pkg::*;
#(
  parameter int NB_SLAVES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = idx_w(NB_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr_i,
  output logic [IDX_W-1:0]                idx_o,
  output logic                            miss_o
);

  logic [ADDR_WIDTH-1:0] lo;
  logic [ADDR_WIDTH-1:0] hi;

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    idx_o  = '0;
    miss_o = 1'b1;
    lo     = '0;
    hi     = '0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      lo = start_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      hi = end_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (addr_i >= lo && addr_i < hi) begin
        idx_o  = IDX_W'(i);
        miss_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_node_timeout.sv
// APB 1-to-N fan-out with runtime address map, stall watchdog
// and sticky capture of the first decode-miss or timeout error.
module apb_node_timeout
  import apb_node_pkg::*;
#(
  parameter int NB_SLAVES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = $clog2(TIMEOUT + 2)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           slave_PADDR,
  input  logic [DATA_WIDTH-1:0]           slave_PWDATA,
  input  logic                            slave_PWRITE,
  input  logic                            slave_PSEL,
  input  logic                            slave_PENABLE,
  output logic [DATA_WIDTH-1:0]           slave_PRDATA,
  output logic                            slave_PREADY,
  output logic                            slave_PSLVERR,
  output logic [ADDR_WIDTH-1:0]           master_PADDR,
  output logic [DATA_WIDTH-1:0]           master_PWDATA,
  output logic                            master_PWRITE,
  output logic                            master_PENABLE,
  output logic [NB_SLAVES-1:0]            master_PSEL,
  input  logic [NB_SLAVES*DATA_WIDTH-1:0] master_PRDATA,
  input  logic [NB_SLAVES-1:0]            master_PREADY,
  input  logic [NB_SLAVES-1:0]            master_PSLVERR,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr_i,
  input  logic                            err_clr_i,
  output logic                            err_valid_o,
  output logic                            err_timeout_o,
  output logic [ADDR_WIDTH-1:0]           err_addr_o
);

  localparam int IDX_W = idx_w(NB_SLAVES);
  localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  miss_q, miss_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_valid_q, err_valid_d;
  logic                  err_to_q, err_to_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_miss;
  logic                  setup;
  logic                  acc_hit;
  logic                  miss_evt;
  logic                  timeout;
  logic                  err_evt;
  logic                  sel_rdy;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  apb_addr_decoder #(
    .NB_SLAVES  (NB_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr_i       (slave_PADDR),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .idx_o        (dec_idx),
    .miss_o       (dec_miss)
  );

  assign master_PADDR  = slave_PADDR;
  assign master_PWDATA = slave_PWDATA;
  assign master_PWRITE = slave_PWRITE;

  assign sel_rdy   = master_PREADY[idx_q];
  assign sel_err   = master_PSLVERR[idx_q];
  assign sel_rdata = master_PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

  assign setup    = (state_q == IDLE) && slave_PSEL && !slave_PENABLE;
  assign acc_hit  = (state_q == ACCESS) && !miss_q;
  assign miss_evt = (state_q == ACCESS) && miss_q;
  // A ready slave in the last tolerated cycle beats the watchdog.
  assign timeout  = (TIMEOUT != 0) && acc_hit
                 && (cnt_q == TO_CNT) && !sel_rdy;
  assign err_evt  = miss_evt || timeout;

  always_comb begin
    master_PSEL    = '0;
    master_PENABLE = 1'b0;
    slave_PREADY   = 1'b0;
    slave_PSLVERR  = 1'b0;
    slave_PRDATA   = '0;
    if (setup && !dec_miss) begin
      master_PSEL[dec_idx] = 1'b1;
    end
    if (acc_hit && !timeout) begin
      master_PSEL[idx_q] = 1'b1;
      master_PENABLE     = slave_PENABLE;
      slave_PREADY       = sel_rdy;
      slave_PSLVERR      = sel_err;
      slave_PRDATA       = sel_rdata;
    end
    if (err_evt) begin
      slave_PREADY  = 1'b1;
      slave_PSLVERR = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          idx_d   = dec_idx;
          miss_d  = dec_miss;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (miss_q || sel_rdy || timeout) begin
          state_d = IDLE;
        end else if (cnt_q != TO_CNT) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear in the same cycle frees the slot for the new error.
  always_comb begin
    err_valid_d = err_valid_q;
    err_to_d    = err_to_q;
    err_addr_d  = err_addr_q;
    if (err_evt && (!err_valid_q || err_clr_i)) begin
      err_valid_d = 1'b1;
      err_to_d    = timeout ? ERR_TIMEOUT : ERR_DECODE;
      err_addr_d  = slave_PADDR;
    end else if (err_clr_i) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      miss_q      <= 1'b0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_to_q    <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      miss_q      <= miss_d;
      cnt_q       <= cnt_d;
      err_valid_q <= err_valid_d;
      err_to_q    <= err_to_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid_o   = err_valid_q;
  assign err_timeout_o = err_to_q;
  assign err_addr_o    = err_addr_q;

endmodule
